// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: widths, zero index, range helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rf_pkg;

   localparam int XLEN_DEF = 32;

   // Width of an address that can name n registers.
   function automatic int addr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Address width is fixed to the full 32-entry architectural space so that
   // instruction fields map straight onto ports regardless of NREGS.
   localparam int RF_AW    = addr_width(32);
   localparam int RF_SLOTS = 1 << RF_AW;

   localparam logic [RF_AW-1:0] REG_ZERO = '0;

   // True for an address that names real storage (not x0, not beyond NREGS).
   function automatic logic reg_live(input logic [RF_AW-1:0] a, input int nregs);
      return (a != REG_ZERO) && (int'(a) < nregs);
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One register-file read mux with optional writeback bypass and operand-ready flag.
// Latency: combinational.
// Backpressure: none; ready=0 tells the stall logic the operand is still pending.
// Ports: addr (read address), we/wr_addr/wr_data (same-cycle writeback),
//        rf/busy (full storage and scoreboard view), data/ready (operand out).
module rf_read_port
   import rf_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1
) (
   input  logic [RF_AW-1:0]                addr,
   input  logic                            we,
   input  logic [RF_AW-1:0]                wr_addr,
   input  logic [XLEN-1:0]                 wr_data,
   input  logic [RF_SLOTS-1:0][XLEN-1:0]   rf,
   input  logic [RF_SLOTS-1:0]             busy,
   output logic [XLEN-1:0]                 data,
   output logic                            ready
);

   always_comb begin
      data  = '0;
      ready = 1'b1;
      // x0 and addresses past NREGS read as a ready zero.
      if (reg_live(addr, NREGS)) begin
         if ((BYPASS != 0) && we && (wr_addr == addr)) begin
            // Writeback this cycle satisfies the operand even if still marked busy.
            data = wr_data;
         end else begin
            data  = rf[addr];
            ready = !busy[addr];
         end
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with a per-register pending scoreboard for RAW/WAW detection.
// Latency: reads and issue_ok combinational; writes, issues and busy_cnt visible next cycle.
// Backpressure: never refuses issue; rs_ready/issue_ok feed the external stall controller.
// Ports: clk, rst (sync, active-high); Rs/read_data/rs_ready (NUM_READ read ports);
//        issue_valid/issue_rd/issue_ok (scoreboard set); we/Rd/data_in (writeback);
//        busy_cnt (registered count of pending registers).
module reg_file_sb
   import rf_pkg::*;
#(
   parameter  int XLEN     = XLEN_DEF,
   parameter  int NREGS    = 32,
   parameter  int NUM_READ = 2,
   parameter  int BYPASS   = 1,
   localparam int AW       = RF_AW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_READ*AW-1:0]   Rs,
   output logic [NUM_READ*XLEN-1:0] read_data,
   output logic [NUM_READ-1:0]      rs_ready,
   input  logic                     issue_valid,
   input  logic [AW-1:0]            issue_rd,
   output logic                     issue_ok,
   input  logic                     we,
   input  logic [AW-1:0]            Rd,
   input  logic [XLEN-1:0]          data_in,
   output logic [AW:0]              busy_cnt
);

   logic [RF_SLOTS-1:0][XLEN-1:0] rf_view;
   logic [RF_SLOTS-1:0]           busy_q;
   logic [RF_SLOTS-1:0]           busy_nxt;
   logic [AW:0]                   cnt_nxt;
   logic                          wr_live;
   logic                          iss_live;

   assign wr_live  = we && reg_live(Rd, NREGS);
   assign iss_live = issue_valid && reg_live(issue_rd, NREGS);

   // Only x1..x(NREGS-1) have storage; every other slot reads as constant zero.
   for (genvar i = 0; i < RF_SLOTS; i++) begin : g_reg
      if (i > 0 && i < NREGS) begin : g_live
         logic [XLEN-1:0] q;
         always_ff @(posedge clk) begin
            if (rst) begin
               q <= '0;
            end else if (wr_live && (Rd == AW'(i))) begin
               q <= data_in;
            end
         end
         assign rf_view[i] = q;
      end else begin : g_zero
         assign rf_view[i] = '0;
      end
   end

   // Clear-on-write is applied before set-on-issue so a same-register
   // issue and writeback leaves the register pending for the new writer.
   always_comb begin
      busy_nxt = busy_q;
      if (wr_live)  busy_nxt[Rd]       = 1'b0;
      if (iss_live) busy_nxt[issue_rd] = 1'b1;
      cnt_nxt = '0;
      for (int i = 0; i < RF_SLOTS; i++) begin
         cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
      end
   end

   // busy_cnt is the registered popcount of the next busy vector, so it
   // tracks busy_q exactly and has no path from issue_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= '0;
         busy_cnt <= '0;
      end else begin
         busy_q   <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

   assign issue_ok = !reg_live(issue_rd, NREGS)
                  || !busy_q[issue_rd]
                  || ((BYPASS != 0) && we && (Rd == issue_rd));

   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      rf_read_port #(
         .XLEN   (XLEN),
         .NREGS  (NREGS),
         .BYPASS (BYPASS)
      ) u_port (
         .addr    (Rs[p*AW +: AW]),
         .we      (we),
         .wr_addr (Rd),
         .wr_data (data_in),
         .rf      (rf_view),
         .busy    (busy_q),
         .data    (read_data[p*XLEN +: XLEN]),
         .ready   (rs_ready[p])
      );
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: three instances (bypass, no bypass, 16 regs x 3 ports)
// share the write/issue stimulus; each step's expected values are written out by hand.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  Rd;
   logic [31:0] data_in;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [9:0]  rs_ab;
   logic [14:0] rs_c;

   logic [63:0] rd_a, rd_b;
   logic [95:0] rd_c;
   logic [1:0]  rdy_a, rdy_b;
   logic [2:0]  rdy_c;
   logic        ok_a, ok_b, ok_c;
   logic [5:0]  cnt_a, cnt_b, cnt_c;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.XLEN(32), .NREGS(32), .NUM_READ(2), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst), .Rs(rs_ab), .read_data(rd_a), .rs_ready(rdy_a),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(ok_a),
      .we(we), .Rd(Rd), .data_in(data_in), .busy_cnt(cnt_a));

   reg_file_sb #(.XLEN(32), .NREGS(32), .NUM_READ(2), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .Rs(rs_ab), .read_data(rd_b), .rs_ready(rdy_b),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(ok_b),
      .we(we), .Rd(Rd), .data_in(data_in), .busy_cnt(cnt_b));

   reg_file_sb #(.XLEN(32), .NREGS(16), .NUM_READ(3), .BYPASS(1)) u_c (
      .clk(clk), .rst(rst), .Rs(rs_c), .read_data(rd_c), .rs_ready(rdy_c),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(ok_c),
      .we(we), .Rd(Rd), .data_in(data_in), .busy_cnt(cnt_c));

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; Rd = '0; data_in = '0;
      issue_valid = 1'b0; issue_rd = '0; rs_ab = '0; rs_c = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Reset state across the whole address space.
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_cnt_c", cnt_c, 0);
      chk("rst_ok_a", ok_a, 1);
      for (int a = 0; a < 32; a++) begin
         rs_ab = {a[4:0], a[4:0]};
         rs_c  = {a[4:0], a[4:0], a[4:0]};
         #1;
         chk("rst_rd_a", rd_a, 0);
         chk("rst_rdy_a", rdy_a, 2'b11);
         chk("rst_rd_b", rd_b, 0);
         chk("rst_rd_c", rd_c, 0);
         chk("rst_rdy_c", rdy_c, 3'b111);
      end

      // Write x5, read next cycle.
      tick();
      we = 1'b1; Rd = 5'd5; data_in = 32'hDEADBEEF;
      tick();
      we = 1'b0; rs_ab = {5'd0, 5'd5};
      #1;
      chk("wr_x5_a", rd_a[31:0], 32'hDEADBEEF);
      chk("wr_x5_b", rd_b[31:0], 32'hDEADBEEF);

      // Write to x0 has no effect, not even via bypass.
      we = 1'b1; Rd = 5'd0; data_in = 32'h1234; rs_ab = {5'd0, 5'd0};
      #1;
      chk("x0_byp_a", rd_a[31:0], 0);
      tick();
      we = 1'b0;
      #1;
      chk("x0_after_a", rd_a[31:0], 0);
      chk("x0_cnt_a", cnt_a, 0);

      // Seed x7, then overwrite it while reading on port 1.
      we = 1'b1; Rd = 5'd7; data_in = 32'h11111111;
      tick();
      we = 1'b1; Rd = 5'd7; data_in = 32'hA5A5A5A5; rs_ab = {5'd7, 5'd5};
      #1;
      chk("byp_rd1_a", rd_a[63:32], 32'hA5A5A5A5);
      chk("byp_rdy1_a", rdy_a[1], 1);
      chk("nobyp_rd1_b", rd_b[63:32], 32'h11111111);
      tick();
      we = 1'b0;
      #1;
      chk("x7_a", rd_a[63:32], 32'hA5A5A5A5);
      chk("x7_b", rd_b[63:32], 32'hA5A5A5A5);

      // Issue x3: pending next cycle; busy_cnt is registered.
      issue_valid = 1'b1; issue_rd = 5'd3;
      #1;
      chk("iss3_ok_pre_a", ok_a, 1);
      chk("iss3_cnt_pre_a", cnt_a, 0);
      tick();
      issue_valid = 1'b0; issue_rd = 5'd3; rs_ab = {5'd5, 5'd3};
      #1;
      chk("x3_rdy_a", rdy_a, 2'b10);
      chk("x3_ok_a", ok_a, 0);
      chk("x3_cnt_a", cnt_a, 1);
      chk("x3_ok_b", ok_b, 0);
      // Writeback to x3: bypass resolves it in the same cycle, no-bypass does not.
      we = 1'b1; Rd = 5'd3; data_in = 32'h33;
      #1;
      chk("x3_wb_ok_a", ok_a, 1);
      chk("x3_wb_rdy_a", rdy_a[0], 1);
      chk("x3_wb_ok_b", ok_b, 0);
      chk("x3_wb_rdy_b", rdy_b[0], 0);
      tick();
      we = 1'b0;
      #1;
      chk("x3_done_rdy_a", rdy_a, 2'b11);
      chk("x3_done_rd_a", rd_a[31:0], 32'h33);
      chk("x3_done_cnt_a", cnt_a, 0);
      chk("x3_done_cnt_b", cnt_b, 0);

      // Issue x9, then re-issue and write x9 together: stays pending, data updates.
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      chk("x9_cnt1_a", cnt_a, 1);
      we = 1'b1; Rd = 5'd9; data_in = 32'h99;
      tick();
      issue_valid = 1'b0; we = 1'b0; rs_ab = {5'd5, 5'd9};
      #1;
      chk("x9_rdy_a", rdy_a[0], 0);
      chk("x9_rdy_b", rdy_b[0], 0);
      chk("x9_rd_a", rd_a[31:0], 32'h99);
      chk("x9_cnt2_a", cnt_a, 1);

      // Issue to x0 is ignored.
      issue_valid = 1'b1; issue_rd = 5'd0;
      #1;
      chk("x0_iss_ok_a", ok_a, 1);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("x0_iss_cnt_a", cnt_a, 1);

      // 16-register instance: out-of-range address reads as ready zero.
      rs_c = {5'd20, 5'd9, 5'd5};
      #1;
      chk("c_rd20", rd_c[95:64], 0);
      chk("c_rdy20", rdy_c[2], 1);
      chk("c_rd5", rd_c[31:0], 32'hDEADBEEF);
      chk("c_rdy9", rdy_c[1], 0);
      chk("c_cnt1", cnt_c, 1);

      // Issue x20: real register in the 32-entry file, ignored in the 16-entry one.
      issue_valid = 1'b1; issue_rd = 5'd20;
      #1;
      chk("c_ok20", ok_c, 1);
      tick();
      issue_rd = 5'd4;
      tick();
      issue_rd = 5'd6;
      tick();
      issue_rd = 5'd10;
      tick();
      issue_valid = 1'b0; issue_rd = 5'd20;
      #1;
      chk("a_ok20", ok_a, 0);
      chk("c_ok20_after", ok_c, 1);
      chk("a_cnt5", cnt_a, 5);
      chk("c_cnt4", cnt_c, 4);

      // Reset with 4 pending in the 16-entry file; reset beats same-cycle write/issue.
      rst = 1'b1; we = 1'b1; Rd = 5'd5; data_in = 32'hFFFF0000;
      issue_valid = 1'b1; issue_rd = 5'd11;
      tick();
      rst = 1'b0; we = 1'b0; issue_valid = 1'b0; issue_rd = 5'd9;
      rs_ab = {5'd9, 5'd5}; rs_c = {5'd9, 5'd5, 5'd4};
      #1;
      chk("rst2_cnt_a", cnt_a, 0);
      chk("rst2_cnt_c", cnt_c, 0);
      chk("rst2_rd_a", rd_a, 0);
      chk("rst2_rdy_a", rdy_a, 2'b11);
      chk("rst2_rd_c", rd_c, 0);
      chk("rst2_rdy_c", rdy_c, 3'b111);
      chk("rst2_ok_a", ok_a, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
